instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Write-side counterpart of the nibble-addressed instruction memory. Accepts 16-bit instruction
//  words on a valid/ready stream (from the testbench or boot interface) and writes each word as four
//  4-bit cells, most-significant nibble at the lowest address. A later fetch reads
//  {mem[a],mem[a+1],mem[a+2],mem[a+3]} and gets back the same word. Holds the CPU while loading.
// PARAMETERS
//  WORD_LEN   16    instruction width, bits (= `WORD_LEN)
//  CELL_W     4     memory cell width, bits (= `MEM_CELL_SIZE); WORD_LEN % CELL_W == 0
//  MEM_SIZE   1024  instruction memory depth, cells (= `INSTR_MEM_SIZE)
//  BASE_ADDR  8     cell address of the first word; must be a multiple of 4
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         reset; synchronous, active-high
//  start      in   1         1-cycle pulse: begin a load at BASE_ADDR
//  s_valid    in   1         input word valid
//  s_ready    out  1         loader can take a word this cycle
//  s_data     in   WORD_LEN  instruction word
//  s_last     in   1         qualifies s_data as the final word of the program
//  mem_we     out  1         cell write strobe
//  mem_addr   out  AW        cell address, AW = $clog2(MEM_SIZE)
//  mem_wdata  out  CELL_W    cell data
//  busy       out  1         load in progress; drives the CPU pipeline hold
//  done       out  1         1-cycle pulse: load completed normally
//  err        out  1         sticky overflow flag; cleared by rst or the next start
//  word_cnt   out  16        words written since the last start
// BEHAVIOUR
//  Reset: state=IDLE. s_ready, mem_we, busy, done and err are 0. mem_addr=0, mem_wdata=0, word_cnt=0.
//  FSM IDLE -> ACCEPT -> WR0..WR3 -> ACCEPT | DONE -> IDLE, plus ERR -> IDLE.
//   IDLE: start=1 -> ACCEPT. Set ptr=BASE_ADDR, word_cnt=0, err=0, busy=1.
//   ACCEPT: s_ready=1 only in this state. Handshake when s_valid && s_ready.
//     On handshake, latch s_data and s_last. If ptr+3 > MEM_SIZE-1, go to ERR with no write.
//     Otherwise go to WR0.
//   WRk (k=0..3): mem_we=1, mem_addr=ptr+k, mem_wdata=word[WORD_LEN-1-4k -: 4].
//     Outputs are registered, so the strobe appears in the cycle the state is WRk.
//   After WR3: ptr+=4 and word_cnt+=1. If the latched last flag is set -> DONE, else -> ACCEPT.
//   DONE: done=1 for exactly 1 cycle, busy falls the same cycle -> IDLE.
//   ERR: err=1 (sticky), busy=0, no further writes -> IDLE.
//  Throughput is 1 word per 5 cycles (ACCEPT + 4 writes). Handshake-to-first-write latency is 1 cycle.
//  mem_we is never high outside WR0..WR3. mem_addr and mem_wdata hold their last value when mem_we=0.
//  start while busy=1 is ignored. s_valid outside ACCEPT is not consumed; the data must be held.
//  s_last on the first word gives a 1-word program. An empty program is not supported.
//  Address never wraps; overflow is always reported via err, never by writing to low addresses.
//  rst mid-load: next cycle is IDLE with mem_we=0. Partially written words stay in memory.
//  word_cnt saturates at 16'hFFFF.
// STRUCTURE
//  Shared defines: WORD_LEN, MEM_CELL_SIZE, INSTR_MEM_SIZE, state encodings (LD_IDLE..LD_ERR).
//  Single module. Nibble select is an inline shift of the latched word; no sub-module is needed.
//  Companion change: the instruction memory gains a synchronous cell write port (we/waddr/wdata).
// TESTING
//  1 start, push 16'h310F with s_last -> writes 3,1,0,F at cells 8..11 on 4 consecutive cycles;
//    done pulses; word_cnt=1; fetch at addr 8 returns 16'h310F.
//  2 three words 16'h310F, 16'h3102, 16'h9120 (last) -> cells 8..19 written, 5 cycles/word, word_cnt=3.
//  3 s_valid toggled randomly -> s_ready only in ACCEPT, no word lost or duplicated, mem_we=0 during stalls.
//  4 MEM_SIZE=16, BASE_ADDR=8, three words -> 2 words written (cells 8..15), 3rd raises err,
//    no write to cell 0, done stays 0.
//  5 rst asserted during WR2 of the first word -> mem_we=0 next cycle, busy=0, word_cnt=0;
//    a new start reloads correctly.
//  6 start pulsed mid-load -> ignored, ptr and word_cnt continue; the start after done restarts at cell 8.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   INSTR_WORD_LEN  : instruction width in bits
//   MEM_CELL_SIZE   : instruction memory cell width in bits
//   INSTR_MEM_SIZE  : instruction memory depth in cells
//   CNT_W           : width of the loaded-word counter
//   ld_state_e      : loader FSM state encodings (LD_IDLE..LD_ERR)
package instr_mem_loader_pkg;

  localparam int INSTR_WORD_LEN = 16;
  localparam int MEM_CELL_SIZE  = 4;
  localparam int INSTR_MEM_SIZE = 1024;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_ACCEPT = 3'd1,
    LD_WR0    = 3'd2,
    LD_WR1    = 3'd3,
    LD_WR2    = 3'd4,
    LD_WR3    = 3'd5,
    LD_DONE   = 3'd6,
    LD_ERR    = 3'd7
  } ld_state_e;

endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Write-side companion of the nibble-addressed instruction memory. Takes
// instruction words from a valid/ready stream and writes each one as
// WORD_LEN/CELL_W consecutive cells, most-significant cell at the lowest
// address, so a fetch of {mem[a],mem[a+1],mem[a+2],mem[a+3]} returns the word.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         1-cycle pulse, begins a load at BASE_ADDR (ignored while busy)
//   s_valid/s_ready/s_data/s_last
//                 input word stream; s_last marks the final program word
//   mem_we/mem_addr/mem_wdata
//                 cell write port towards the instruction memory
//   busy          load in progress (holds the CPU pipeline)
//   done          1-cycle pulse when a load completes normally
//   err           sticky overflow flag, cleared by rst or the next start
//   word_cnt      words written since the last start (saturating)
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int WORD_LEN  = INSTR_WORD_LEN,
  parameter int CELL_W    = MEM_CELL_SIZE,
  parameter int MEM_SIZE  = INSTR_MEM_SIZE,
  parameter int BASE_ADDR = 8,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_LEN-1:0] s_data,
  input  logic                s_last,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [CELL_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    word_cnt
);

  // The FSM has exactly four write states, so a word is four cells.
  localparam int CPW = WORD_LEN / CELL_W;
  // One extra pointer bit so the pointer can reach MEM_SIZE after the last
  // word without wrapping back to low addresses.
  localparam int PW  = AW + 1;
  localparam logic [PW-1:0] BASE_PTR   = PW'(BASE_ADDR);
  localparam logic [PW-1:0] PTR_STEP   = PW'(CPW);
  // Highest pointer at which a whole word still fits in memory.
  localparam logic [PW-1:0] LAST_START = PW'(MEM_SIZE - CPW);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  ld_state_e            state;
  logic [PW-1:0]        ptr;
  // Latched word, shifted left one cell per write so the next cell to emit
  // is always in the top bits.
  logic [WORD_LEN-1:0]  word_sh;
  logic                 last_q;

  // All outputs are registered: each is set on the transition into the
  // state in which it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LD_IDLE;
      ptr       <= BASE_PTR;
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (start) begin
            state    <= LD_ACCEPT;
            ptr      <= BASE_PTR;
            word_cnt <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
          end
        end
        LD_ACCEPT: begin
          if (s_valid && s_ready) begin
            s_ready <= 1'b0;
            last_q  <= s_last;
            if (ptr > LAST_START) begin
              // Word would run past the end of memory: drop it, no write.
              state <= LD_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= LD_WR0;
              mem_we    <= 1'b1;
              mem_addr  <= ptr[AW-1:0];
              mem_wdata <= s_data[WORD_LEN-1 -: CELL_W];
              word_sh   <= s_data << CELL_W;
            end
          end
        end
        LD_WR0, LD_WR1, LD_WR2: begin
          case (state)
            LD_WR0:  state <= LD_WR1;
            LD_WR1:  state <= LD_WR2;
            default: state <= LD_WR3;
          endcase
          mem_addr  <= mem_addr + AW'(1);
          mem_wdata <= word_sh[WORD_LEN-1 -: CELL_W];
          word_sh   <= word_sh << CELL_W;
        end
        LD_WR3: begin
          // mem_addr/mem_wdata keep their last value while the strobe is low.
          mem_we   <= 1'b0;
          ptr      <= ptr + PTR_STEP;
          word_cnt <= sat_inc(word_cnt);
          if (last_q) begin
            state <= LD_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= LD_ACCEPT;
            s_ready <= 1'b1;
          end
        end
        LD_DONE: state <= LD_IDLE;
        LD_ERR:  state <= LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader. A full-size instance and a
// 16-cell instance share the same start/stream inputs; the small one runs
// out of memory on the third word of a three-word program.
module tb_instr_mem_loader;

  localparam int AW  = 10;
  localparam int AWS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start, s_valid, s_last;
  logic [15:0] s_data;

  logic          s_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata;
  logic [15:0]   word_cnt;

  logic           s_ready_s, mem_we_s, busy_s, done_s, err_s;
  logic [AWS-1:0] mem_addr_s;
  logic [3:0]     mem_wdata_s;
  logic [15:0]    word_cnt_s;

  instr_mem_loader #(.WORD_LEN(16), .CELL_W(4), .MEM_SIZE(1024), .BASE_ADDR(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  instr_mem_loader #(.WORD_LEN(16), .CELL_W(4), .MEM_SIZE(16), .BASE_ADDR(8)) dut_small (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data), .s_last(s_last),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .busy(busy_s), .done(done_s), .err(err_s), .word_cnt(word_cnt_s)
  );

  int vectors     = 0;
  int miscompares = 0;

  int   cyc = 0, viol = 0, done_cnt = 0, done_s_cnt = 0, s_wr_cnt = 0, s_bad = 0;
  logic prev_done = 1'b0;

  logic [3:0] mem_model [0:1023];
  logic [3:0] mem_s     [0:15];

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t         wq[$];
  int          hs_q[$];
  logic [15:0] exp_w[$];

  // Memory models: a cell is written at the edge that ends a strobe cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we === 1'b1) begin
      mem_model[mem_addr] <= mem_wdata;
      wq.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
    end
    if (mem_we_s === 1'b1) begin
      mem_s[mem_addr_s] <= mem_wdata_s;
      s_wr_cnt <= s_wr_cnt + 1;
      if (mem_addr_s < 4'd8) s_bad <= s_bad + 1;
    end
  end

  // Protocol monitor on the main instance.
  always @(negedge clk) begin
    if (!rst) begin
      viol <= viol + ((mem_we && !busy) ? 1 : 0) + ((mem_we && s_ready) ? 1 : 0)
                   + ((s_ready && !busy) ? 1 : 0) + ((done && prev_done) ? 1 : 0)
                   + ((done && busy) ? 1 : 0);
      done_cnt   <= done_cnt + (done ? 1 : 0);
      done_s_cnt <= done_s_cnt + (done_s ? 1 : 0);
    end
    prev_done <= done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fetch(input int a);
    return {mem_model[a], mem_model[a+1], mem_model[a+2], mem_model[a+3]};
  endfunction

  function automatic logic [15:0] fetch_s(input int a);
    return {mem_s[a], mem_s[a+1], mem_s[a+2], mem_s[a+3]};
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Holds valid low for gap cycles, then offers one word until accepted.
  task automatic push(input logic [15:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    s_data = d; s_last = l; s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      chk("push_ready", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    hs_q.push_back(cyc);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
  endtask

  // Compares the logged writes and the memory image against exp_w at base.
  task automatic check_load(input string tag, input int base);
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_w.size() * 4));
    for (int j = 0; j < exp_w.size(); j++) begin
      chk({tag, "_fetch"}, 32'(fetch(base + 4*j)), 32'(exp_w[j]));
      for (int k = 0; k < 4; k++) begin
        if (4*j + k < wq.size()) begin
          chk({tag, "_addr"}, 32'(wq[4*j+k].addr), 32'(base + 4*j + k));
          chk({tag, "_nibble"}, 32'(wq[4*j+k].data), 32'(exp_w[j][15-4*k -: 4]));
          if (j < hs_q.size())
            chk({tag, "_wr_cycle"}, 32'(wq[4*j+k].cyc), 32'(hs_q[j] + 1 + k));
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, ds0, sw0;
    start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);

    // Single-word program
    wq.delete(); hs_q.delete(); exp_w = '{16'h310F};
    d0 = done_cnt;
    pulse_start();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    push(16'h310F, 1'b1, 0);
    wait_done("t1");
    check_load("t1", 8);
    chk("t1_word_cnt", 32'(word_cnt), 32'd1);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // Three words back to back; the small instance overflows on the third
    wq.delete(); hs_q.delete(); exp_w = '{16'h310F, 16'h3102, 16'h9120};
    sw0 = s_wr_cnt; ds0 = done_s_cnt;
    pulse_start();
    push(16'h310F, 1'b0, 0);
    push(16'h3102, 1'b0, 0);
    push(16'h9120, 1'b1, 0);
    wait_done("t2");
    check_load("t2", 8);
    chk("t2_word_cnt", 32'(word_cnt), 32'd3);
    if (hs_q.size() == 3) begin
      chk("t2_word_period_1", 32'(hs_q[1] - hs_q[0]), 32'd5);
      chk("t2_word_period_2", 32'(hs_q[2] - hs_q[1]), 32'd5);
    end
    chk("t4_err",        32'(err_s),               32'd1);
    chk("t4_busy",       32'(busy_s),              32'd0);
    chk("t4_nwrites",    32'(s_wr_cnt - sw0),      32'd8);
    chk("t4_low_writes", 32'(s_bad),               32'd0);
    chk("t4_done",       32'(done_s_cnt - ds0),    32'd0);
    chk("t4_word_cnt",   32'(word_cnt_s),          32'd2);
    chk("t4_fetch8",     32'(fetch_s(8)),          32'h310F);
    chk("t4_fetch12",    32'(fetch_s(12)),         32'h3102);

    // Irregular valid timing
    wq.delete(); hs_q.delete(); exp_w = '{16'hA5C3, 16'h0001, 16'hFFFF, 16'h1234};
    pulse_start();
    chk("t3_err_cleared_by_start", 32'(err_s), 32'd0);
    for (int i = 0; i < 4; i++)
      push(exp_w[i], (i == 3), int'($urandom_range(0, 3)));
    wait_done("t3");
    check_load("t3", 8);
    chk("t3_word_cnt", 32'(word_cnt), 32'd4);
    for (int i = 1; i < hs_q.size(); i++)
      chk("t3_min_period", 32'(hs_q[i] - hs_q[i-1] >= 5), 32'd1);

    // Reset during the third cell write of the first word
    wq.delete(); hs_q.delete();
    pulse_start();
    push(16'h310F, 1'b0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_in_wr2_we",   32'(mem_we),   32'd1);
    chk("t5_in_wr2_addr", 32'(mem_addr), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_mem_we",   32'(mem_we),   32'd0);
    chk("t5_rst_busy",     32'(busy),     32'd0);
    chk("t5_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("t5_rst_s_ready",  32'(s_ready),  32'd0);
    @(negedge clk);
    wq.delete(); hs_q.delete(); exp_w = '{16'h3102};
    pulse_start();
    push(16'h3102, 1'b1, 0);
    wait_done("t5");
    check_load("t5", 8);
    chk("t5_word_cnt", 32'(word_cnt), 32'd1);

    // start during a load is ignored; start after done restarts at cell 8
    wq.delete(); hs_q.delete(); exp_w = '{16'h310F, 16'h9120};
    pulse_start();
    push(16'h310F, 1'b0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    push(16'h9120, 1'b1, 0);
    wait_done("t6a");
    check_load("t6a", 8);
    chk("t6a_word_cnt", 32'(word_cnt), 32'd2);
    wq.delete(); hs_q.delete(); exp_w = '{16'hABCD};
    pulse_start();
    push(16'hABCD, 1'b1, 0);
    wait_done("t6b");
    check_load("t6b", 8);
    chk("t6b_word_cnt", 32'(word_cnt), 32'd1);

    repeat (2) @(negedge clk);
    #1;
    chk("protocol_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
